// File: rtl/cvxif_buf_pkg.sv
// Shared types for the CV-X-IF offload buffer: entry layout and default sizing.
package cvxif_buf_pkg;

    localparam int CVXIF_BUF_XLEN     = 64;
    localparam int CVXIF_BUF_ID_WIDTH = 3;
    localparam int CVXIF_BUF_DEPTH    = 4;

    typedef struct packed {
        logic [31:0]                   instr;
        logic [CVXIF_BUF_XLEN-1:0]     rs1;
        logic [CVXIF_BUF_XLEN-1:0]     rs2;
        logic [CVXIF_BUF_ID_WIDTH-1:0] id;
    } offload_entry_t;

endpackage

// File: rtl/cvxif_buf_fifo.sv
// DEPTH-entry FIFO of offload entries with flush; the head output holds its
// last shown value while the FIFO is empty.
module cvxif_buf_fifo
    import cvxif_buf_pkg::*;
#(
    parameter int  DEPTH = CVXIF_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  offload_entry_t   push_data_i,
    input  logic             pop_i,
    output offload_entry_t   head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    offload_entry_t   mem [DEPTH];
    offload_entry_t   last_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Flush wins over both ports so no handshake completes in a flush cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // NOTE: payload storage has no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Shadow of the displayed head, shown while empty so x_* never drift.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= '0;
        end else if (!empty_o) begin
            last_q <= mem[rd_ptr_q];
        end
    end

    assign head_o = empty_o ? last_q : mem[rd_ptr_q];

endmodule

// File: rtl/cvxif_offload_buffer.sv
// Decoupling buffer between the issue stage and the CV-X-IF coprocessor port:
// queues offloaded instructions with IDs and registers the commit/kill stream.
module cvxif_offload_buffer
    import cvxif_buf_pkg::*;
#(
    // XLEN and ID_WIDTH must match the package entry layout.
    parameter int XLEN     = CVXIF_BUF_XLEN,
    parameter int DEPTH    = CVXIF_BUF_DEPTH,
    parameter int ID_WIDTH = CVXIF_BUF_ID_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [XLEN-1:0]          issue_rs1_i,
    input  logic [XLEN-1:0]          issue_rs2_i,
    output logic [ID_WIDTH-1:0]      issue_id_o,
    output logic                     x_issue_valid_o,
    input  logic                     x_issue_ready_i,
    output logic [31:0]              x_instr_o,
    output logic [XLEN-1:0]          x_rs1_o,
    output logic [XLEN-1:0]          x_rs2_o,
    output logic [ID_WIDTH-1:0]      x_id_o,
    input  logic                     commit_valid_i,
    input  logic [ID_WIDTH-1:0]      commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     x_commit_valid_o,
    output logic [ID_WIDTH-1:0]      x_commit_id_o,
    output logic                     x_commit_kill_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    offload_entry_t      push_entry;
    offload_entry_t      head;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [ID_WIDTH-1:0] next_id_q;

    assign issue_ready_o   = !full && !flush_i;
    assign issue_id_o      = next_id_q;
    assign push            = issue_valid_i && issue_ready_o;
    assign x_issue_valid_o = !empty;
    assign pop             = x_issue_valid_o && x_issue_ready_i && !flush_i;

    assign push_entry.instr = issue_instr_i;
    assign push_entry.rs1   = issue_rs1_i;
    assign push_entry.rs2   = issue_rs2_i;
    assign push_entry.id    = next_id_q;

    cvxif_buf_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count_o)
    );

    assign x_instr_o = head.instr;
    assign x_rs1_o   = head.rs1;
    assign x_rs2_o   = head.rs2;
    assign x_id_o    = head.id;

    // IDs survive flush so they stay unique against in-flight coprocessor state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            next_id_q <= '0;
        end else if (push) begin
            next_id_q <= next_id_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_commit_valid_o <= 1'b0;
            x_commit_id_o    <= '0;
            x_commit_kill_o  <= 1'b0;
        end else begin
            x_commit_valid_o <= commit_valid_i;
            if (commit_valid_i) begin
                x_commit_id_o   <= commit_id_i;
                x_commit_kill_o <= commit_kill_i;
            end
        end
    end

endmodule

// File: tb/tb_cvxif_offload_buffer.sv
// Scoreboard bench for cvxif_offload_buffer: a negedge monitor predicts
// occupancy, ready/valid and head contents; scenario tasks add targeted checks.
module tb_cvxif_offload_buffer;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int IDW   = 3;
    localparam int CW    = 3;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [31:0]     issue_instr_i;
    logic [XLEN-1:0] issue_rs1_i;
    logic [XLEN-1:0] issue_rs2_i;
    logic [IDW-1:0]  issue_id_o;
    logic            x_issue_valid_o;
    logic            x_issue_ready_i;
    logic [31:0]     x_instr_o;
    logic [XLEN-1:0] x_rs1_o;
    logic [XLEN-1:0] x_rs2_o;
    logic [IDW-1:0]  x_id_o;
    logic            commit_valid_i;
    logic [IDW-1:0]  commit_id_i;
    logic            commit_kill_i;
    logic            x_commit_valid_o;
    logic [IDW-1:0]  x_commit_id_o;
    logic            x_commit_kill_o;
    logic [CW-1:0]   count_o;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [IDW-1:0]  id;
    } exp_t;

    exp_t           sb[$];
    exp_t           e;
    logic [IDW-1:0] model_id = '0;
    int             checks = 0;
    int             errors = 0;

    cvxif_offload_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ID_WIDTH(IDW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_instr_i    (issue_instr_i),
        .issue_rs1_i      (issue_rs1_i),
        .issue_rs2_i      (issue_rs2_i),
        .issue_id_o       (issue_id_o),
        .x_issue_valid_o  (x_issue_valid_o),
        .x_issue_ready_i  (x_issue_ready_i),
        .x_instr_o        (x_instr_o),
        .x_rs1_o          (x_rs1_o),
        .x_rs2_o          (x_rs2_o),
        .x_id_o           (x_id_o),
        .commit_valid_i   (commit_valid_i),
        .commit_id_i      (commit_id_i),
        .commit_kill_i    (commit_kill_i),
        .x_commit_valid_o (x_commit_valid_o),
        .x_commit_id_o    (x_commit_id_o),
        .x_commit_kill_o  (x_commit_kill_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge; the monitor samples at negedge.
    always @(negedge clk) begin
        if (rst_i) begin
            sb.delete();
            model_id = '0;
        end else begin
            checks++;
            if (count_o !== 3'(sb.size())) begin
                errors++;
                $display("FAIL mon_count: got %0d expected %0d @%0t", count_o, sb.size(), $time);
            end
            checks++;
            if (x_issue_valid_o !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL mon_x_valid: got %0b expected %0b @%0t", x_issue_valid_o, sb.size() != 0, $time);
            end
            checks++;
            if (issue_ready_o !== ((sb.size() < DEPTH) && !flush_i)) begin
                errors++;
                $display("FAIL mon_ready: got %0b expected %0b @%0t", issue_ready_o,
                         (sb.size() < DEPTH) && !flush_i, $time);
            end
            if (x_issue_valid_o && x_issue_ready_i && !flush_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_pop_empty: pop with empty scoreboard @%0t", $time);
                end else begin
                    e = sb.pop_front();
                    if (x_instr_o !== e.instr || x_rs1_o !== e.rs1 || x_rs2_o !== e.rs2 || x_id_o !== e.id) begin
                        errors++;
                        $display("FAIL mon_head: got instr=%h rs1=%0d id=%0d expected instr=%h rs1=%0d id=%0d @%0t",
                                 x_instr_o, x_rs1_o, x_id_o, e.instr, e.rs1, e.id, $time);
                    end
                end
            end
            if (issue_valid_i && issue_ready_o) begin
                checks++;
                if (issue_id_o !== model_id) begin
                    errors++;
                    $display("FAIL mon_issue_id: got %0d expected %0d @%0t", issue_id_o, model_id, $time);
                end
                sb.push_back('{instr: issue_instr_i, rs1: issue_rs1_i, rs2: issue_rs2_i, id: model_id});
                model_id = model_id + 1'b1;
            end
            if (flush_i) sb.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        issue_valid_i   = 1'b0;
        x_issue_ready_i = 1'b1;
        for (int i = 0; i < 20 && count_o != 0; i++) tick();
        checks++;
        if (count_o !== 3'd0) begin
            errors++;
            $display("FAIL drain_timeout: count %0d expected 0", count_o);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (issue_ready_o !== 1'b1 || x_issue_valid_o !== 1'b0 || count_o !== 3'd0 || issue_id_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%0b xvalid=%0b count=%0d id=%0d expected 1 0 0 0",
                     issue_ready_o, x_issue_valid_o, count_o, issue_id_o);
        end
        checks++;
        if (x_instr_o !== 32'h0 || x_rs1_o !== '0 || x_rs2_o !== '0 || x_id_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_head: instr=%h rs1=%h rs2=%h id=%0d expected all 0", x_instr_o, x_rs1_o, x_rs2_o, x_id_o);
        end
        checks++;
        if (x_commit_valid_o !== 1'b0 || x_commit_id_o !== 3'd0 || x_commit_kill_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_commit: v=%0b id=%0d k=%0b expected 0 0 0", x_commit_valid_o, x_commit_id_o, x_commit_kill_o);
        end
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] instrs [3] = '{32'h0000_000B, 32'h1000_000B, 32'h2000_000B};
        x_issue_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = instrs[i];
            issue_rs1_i   = 64'(i);
            issue_rs2_i   = ~64'(i);
            #1;
            checks++;
            if (issue_id_o !== 3'(i)) begin
                errors++;
                $display("FAIL basic_issue_id: got %0d expected %0d", issue_id_o, i);
            end
            if (i == 0) begin
                checks++;
                if (x_issue_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_no_bypass: x_valid %0b expected 0", x_issue_valid_o);
                end
            end
            tick();
            checks++;
            if (x_issue_valid_o !== 1'b1 || x_id_o !== 3'(i) || x_instr_o !== instrs[i]) begin
                errors++;
                $display("FAIL basic_latency: xvalid=%0b id=%0d instr=%h expected 1 %0d %h",
                         x_issue_valid_o, x_id_o, x_instr_o, i, instrs[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        x_issue_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = 32'h4000_000B + 32'(i);
            issue_rs1_i   = 64'(100 + i);
            #1;
            checks++;
            if (i < 4 && issue_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_ready: push %0d ready %0b expected 1", i, issue_ready_o);
            end else if (i == 4 && (issue_ready_o !== 1'b0 || count_o !== 3'd4)) begin
                errors++;
                $display("FAIL bp_full: ready=%0b count=%0d expected 0 4", issue_ready_o, count_o);
            end
            if (i > 0) begin
                checks++;
                if (x_id_o !== 3'd3 || x_instr_o !== 32'h4000_000B) begin
                    errors++;
                    $display("FAIL bp_head_hold: id=%0d instr=%h expected 3 4000000b", x_id_o, x_instr_o);
                end
            end
            tick();
        end
        issue_valid_i = 1'b0;
    endtask

    task automatic test_full_push_pop();
        issue_valid_i   = 1'b1;
        issue_instr_i   = 32'h5000_000B;
        issue_rs1_i     = 64'd200;
        x_issue_ready_i = 1'b1;
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_same_cycle: got %0b expected 0", issue_ready_o);
        end
        tick();
        checks++;
        if (count_o !== 3'd3 || issue_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop: count=%0d ready=%0b expected 3 1", count_o, issue_ready_o);
        end
        tick();
        checks++;
        if (count_o !== 3'd3) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d expected 3", count_o);
        end
        drain();
    endtask

    task automatic test_wrap();
        int k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            issue_valid_i   = 1'b1;
            issue_instr_i   = 32'h0000_100B;
            issue_rs1_i     = 64'(k);
            issue_rs2_i     = 64'(1000 + k);
            x_issue_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (issue_ready_o) begin
                checks++;
                if (issue_id_o !== 3'(k)) begin
                    errors++;
                    $display("FAIL wrap_id: instr %0d id %0d expected %0d", k, issue_id_o, k % 8);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 10) begin
            errors++;
            $display("FAIL wrap_budget: accepted %0d expected 10", k);
        end
        drain();
    endtask

    task automatic test_flush();
        x_issue_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = 32'h6000_000B + 32'(i);
            issue_rs1_i   = 64'(300 + i);
            tick();
        end
        checks++;
        if (count_o !== 3'd3) begin
            errors++;
            $display("FAIL flush_setup: count %0d expected 3", count_o);
        end
        flush_i         = 1'b1;
        x_issue_ready_i = 1'b1;
        issue_instr_i   = 32'h6F00_000B;
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %0b expected 0", issue_ready_o);
        end
        tick();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        #1;
        checks++;
        if (count_o !== 3'd0 || x_issue_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: count=%0d xvalid=%0b expected 0 0", count_o, x_issue_valid_o);
        end
        checks++;
        if (x_id_o !== 3'd2 || x_instr_o !== 32'h6000_000B) begin
            errors++;
            $display("FAIL flush_hold: id=%0d instr=%h expected 2 6000000b", x_id_o, x_instr_o);
        end
        checks++;
        if (issue_id_o !== 3'd5) begin
            errors++;
            $display("FAIL flush_next_id: got %0d expected 5", issue_id_o);
        end
        issue_valid_i = 1'b1;
        issue_instr_i = 32'h7000_000B;
        tick();
        drain();
    endtask

    task automatic test_commit();
        commit_valid_i = 1'b1;
        commit_id_i    = 3'd5;
        commit_kill_i  = 1'b1;
        tick();
        commit_valid_i = 1'b0;
        commit_id_i    = 3'd2;
        commit_kill_i  = 1'b0;
        checks++;
        if (x_commit_valid_o !== 1'b1 || x_commit_id_o !== 3'd5 || x_commit_kill_o !== 1'b1) begin
            errors++;
            $display("FAIL commit_n1: v=%0b id=%0d k=%0b expected 1 5 1", x_commit_valid_o, x_commit_id_o, x_commit_kill_o);
        end
        tick();
        checks++;
        if (x_commit_valid_o !== 1'b0 || x_commit_id_o !== 3'd5 || x_commit_kill_o !== 1'b1) begin
            errors++;
            $display("FAIL commit_n2: v=%0b id=%0d k=%0b expected 0 5 1", x_commit_valid_o, x_commit_id_o, x_commit_kill_o);
        end
    endtask

    task automatic test_async_reset();
        x_issue_ready_i = 1'b0;
        commit_valid_i  = 1'b1;
        commit_id_i     = 3'd3;
        for (int i = 0; i < 2; i++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = 32'h8000_000B + 32'(i);
            issue_rs1_i   = 64'(400 + i);
            tick();
        end
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (count_o !== 3'd0 || x_issue_valid_o !== 1'b0 || issue_ready_o !== 1'b1 || issue_id_o !== 3'd0) begin
            errors++;
            $display("FAIL areset_ctrl: count=%0d xvalid=%0b ready=%0b id=%0d expected 0 0 1 0",
                     count_o, x_issue_valid_o, issue_ready_o, issue_id_o);
        end
        checks++;
        if (x_instr_o !== 32'h0 || x_id_o !== 3'd0 || x_commit_valid_o !== 1'b0 || x_commit_id_o !== 3'd0) begin
            errors++;
            $display("FAIL areset_outputs: instr=%h id=%0d cv=%0b cid=%0d expected 0 0 0 0",
                     x_instr_o, x_id_o, x_commit_valid_o, x_commit_id_o);
        end
        tick();
        rst_i           = 1'b0;
        x_issue_ready_i = 1'b1;
        issue_valid_i   = 1'b1;
        issue_instr_i   = 32'h9000_000B;
        #1;
        checks++;
        if (issue_id_o !== 3'd0 || issue_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_resume: id=%0d ready=%0b expected 0 1", issue_id_o, issue_ready_o);
        end
        tick();
        drain();
    endtask

    initial begin
        rst_i           = 1'b1;
        flush_i         = 1'b0;
        issue_valid_i   = 1'b0;
        issue_instr_i   = '0;
        issue_rs1_i     = '0;
        issue_rs2_i     = '0;
        x_issue_ready_i = 1'b0;
        commit_valid_i  = 1'b0;
        commit_id_i     = '0;
        commit_kill_i   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_commit();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
